// File: rtl/multicycle_control.sv
// Multicycle control unit and PC holder for the 64-bit datapath: FETCH/DECODE/EXEC/MEM/WB sequencing.
// 3 cycles (beq), 4 cycles (R-type, sd) or 5 cycles (ld) per instruction; no backpressure, HALT/ERROR exit only by reset.
module multicycle_control #(
  parameter int IM_L  = 16,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              im_data,
  input  logic                     ALUzero,
  input  logic [$clog2(IM_L)-1:0] PCnext,
  output logic [$clog2(IM_L)-1:0] PC,
  output logic                     RegWrite,
  output logic                     ALUsrc,
  output logic                     PCsrc,
  output logic                     MemtoReg,
  output logic [1:0]               instType,
  output logic [3:0]               ALUop,
  output logic                     dm_we,
  output logic                     halted,
  output logic                     illegal,
  output logic [CNT_W-1:0]         instret
);
  localparam int PC_W = $clog2(IM_L);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERROR
  } state_t;

  localparam logic [1:0] T_R = 2'b00, T_I = 2'b01, T_S = 2'b10, T_B = 2'b11;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0110;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [31:0]        ir_q, ir_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic [3:0]         alu_op_q, alu_op_d;
  logic               alu_src_q, alu_src_d;
  logic [1:0]         inst_type_q, inst_type_d;
  logic               mem_to_reg_q, mem_to_reg_d;

  logic               dec_ok, dec_halt, dec_src, dec_m2r;
  logic [3:0]         dec_op;
  logic [1:0]         dec_type;
  logic               commit;

  // Pure decode of the held instruction word; only sampled into the field registers in DECODE.
  always_comb begin
    dec_ok   = 1'b0;
    dec_halt = 1'b0;
    dec_op   = OP_ADD;
    dec_src  = 1'b0;
    dec_type = T_R;
    dec_m2r  = 1'b0;
    if (ir_q == 32'h0010_0073) begin
      dec_halt = 1'b1;
    end else begin
      case (ir_q[6:0])
        7'b0110011: begin
          dec_src  = 1'b1;
          dec_type = T_R;
          dec_ok   = 1'b1;
          case ({ir_q[31:25], ir_q[14:12]})
            10'b0000000_000: dec_op = OP_ADD;
            10'b0100000_000: dec_op = OP_SUB;
            10'b0000000_111: dec_op = OP_AND;
            10'b0000000_110: dec_op = OP_OR;
            default:         dec_ok = 1'b0;
          endcase
        end
        7'b0000011: begin
          dec_ok   = (ir_q[14:12] == 3'b011);
          dec_type = T_I;
          dec_m2r  = 1'b1;
        end
        7'b0100011: begin
          dec_ok   = (ir_q[14:12] == 3'b011);
          dec_type = T_S;
        end
        7'b1100011: begin
          dec_ok   = (ir_q[14:12] == 3'b000);
          dec_op   = OP_SUB;
          dec_src  = 1'b1;
          dec_type = T_B;
        end
        default: dec_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    instret_d    = instret_q;
    alu_op_d     = alu_op_q;
    alu_src_d    = alu_src_q;
    inst_type_d  = inst_type_q;
    mem_to_reg_d = mem_to_reg_q;
    commit       = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_d    = im_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (dec_halt) begin
          state_d   = S_HALT;
          instret_d = instret_q + CNT_W'(1);
        end else if (dec_ok) begin
          state_d      = S_EXEC;
          alu_op_d     = dec_op;
          alu_src_d    = dec_src;
          inst_type_d  = dec_type;
          mem_to_reg_d = dec_m2r;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_EXEC: begin
        case (inst_type_q)
          T_R:     state_d = S_WB;
          T_I,
          T_S:     state_d = S_MEM;
          default: commit = 1'b1;
        endcase
      end
      S_MEM: begin
        if (inst_type_q == T_I) state_d = S_WB;
        else                    commit  = 1'b1;
      end
      S_WB:    commit = 1'b1;
      default: state_d = state_q;
    endcase
    // Last cycle of every retiring instruction except ebreak, which leaves PC alone.
    if (commit) begin
      pc_d      = PCnext;
      instret_d = instret_q + CNT_W'(1);
      state_d   = S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= '0;
      ir_q         <= '0;
      instret_q    <= '0;
      alu_op_q     <= '0;
      alu_src_q    <= 1'b0;
      inst_type_q  <= '0;
      mem_to_reg_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      instret_q    <= instret_d;
      alu_op_q     <= alu_op_d;
      alu_src_q    <= alu_src_d;
      inst_type_q  <= inst_type_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  assign PC       = pc_q;
  assign instret  = instret_q;
  assign ALUop    = alu_op_q;
  assign ALUsrc   = alu_src_q;
  assign instType = inst_type_q;
  assign MemtoReg = mem_to_reg_q;
  assign RegWrite = (state_q == S_WB);
  assign dm_we    = (state_q == S_MEM) && (inst_type_q == T_S);
  assign PCsrc    = (state_q == S_EXEC) && (inst_type_q == T_B) && ALUzero;
  assign halted   = (state_q == S_HALT);
  assign illegal  = (state_q == S_ERROR);
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: an instruction ROM indexed by PC and a next-PC adder (+1, or +4 when branching).
module tb_multicycle_control;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] im_data;
  logic        alu_zero;
  logic [3:0]  pc_next;
  logic [3:0]  pc;
  logic        reg_write, alu_src, pc_src, mem_to_reg, dm_we, halted, illegal;
  logic [1:0]  inst_type;
  logic [3:0]  alu_op;
  logic [31:0] instret;
  logic [31:0] imem [16];

  int errors = 0;
  int checks = 0;

  multicycle_control #(.IM_L(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .im_data(im_data), .ALUzero(alu_zero), .PCnext(pc_next),
    .PC(pc), .RegWrite(reg_write), .ALUsrc(alu_src), .PCsrc(pc_src), .MemtoReg(mem_to_reg),
    .instType(inst_type), .ALUop(alu_op), .dm_we(dm_we), .halted(halted), .illegal(illegal),
    .instret(instret)
  );

  always #5 clk = ~clk;

  assign im_data = imem[pc];
  assign pc_next = pc_src ? pc + 4'd4 : pc + 4'd1;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_strobes"}, {reg_write, dm_we, pc_src}, 3'b000);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    alu_zero = 1'b0;
    for (int i = 0; i < 16; i++) imem[i] = 32'h0000_0013;

    // Program A: add, sub, beq taken (2->6), sd, ld, beq not taken, ebreak
    imem[0] = 32'h0020_81B3;
    imem[1] = 32'h4020_81B3;
    imem[2] = 32'h0000_0263;
    imem[6] = 32'h0050_3823;
    imem[7] = 32'h0080_3283;
    imem[8] = 32'h0020_8263;
    imem[9] = 32'h0010_0073;

    do_reset(2);
    chk("rst_pc", pc, 0);
    chk("rst_instret", instret, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_fields", {alu_op, alu_src, inst_type, mem_to_reg}, 0);
    chk_quiet("add_c1");
    tick(1);
    chk_quiet("add_c2");
    tick(1);
    chk("add_c3_fields", {alu_op, alu_src, inst_type, mem_to_reg}, {4'b0010, 1'b1, 2'b00, 1'b0});
    chk_quiet("add_c3");
    tick(1);
    chk("add_c4_regwrite", {reg_write, dm_we, pc_src}, 3'b100);
    tick(1);
    chk("add_done", {pc, instret}, {4'd1, 32'd1});
    chk_quiet("sub_c1");

    tick(2);
    chk("sub_fields", {alu_op, alu_src, inst_type}, {4'b0110, 1'b1, 2'b00});
    tick(1);
    chk("sub_c4_regwrite", reg_write, 1);
    tick(1);
    chk("sub_done", {pc, instret}, {4'd2, 32'd2});

    alu_zero = 1'b1;
    tick(2);
    chk("beq_t_exec", {pc_src, reg_write, dm_we, alu_op, alu_src, inst_type}, {3'b100, 4'b0110, 1'b1, 2'b11});
    tick(1);
    chk("beq_t_done", {pc, instret}, {4'd6, 32'd3});
    chk_quiet("beq_t_after");
    alu_zero = 1'b0;

    tick(2);
    chk("sd_exec", {alu_op, alu_src, inst_type}, {4'b0010, 1'b0, 2'b10});
    chk_quiet("sd_exec");
    tick(1);
    chk("sd_mem_we", {reg_write, dm_we, pc_src}, 3'b010);
    tick(1);
    chk("sd_done", {pc, instret}, {4'd7, 32'd4});
    chk_quiet("sd_after");

    tick(2);
    chk("ld_exec", {alu_op, alu_src, inst_type, mem_to_reg}, {4'b0010, 1'b0, 2'b01, 1'b1});
    tick(1);
    chk_quiet("ld_mem");
    tick(1);
    chk("ld_wb", {reg_write, dm_we, mem_to_reg}, 3'b101);
    tick(1);
    chk("ld_done", {pc, instret}, {4'd8, 32'd5});

    tick(2);
    chk("beq_nt_exec", {pc_src, inst_type}, {1'b0, 2'b11});
    tick(1);
    chk("beq_nt_done", {pc, instret}, {4'd9, 32'd6});

    tick(2);
    chk("ebreak_halt", {halted, illegal, pc, instret}, {1'b1, 1'b0, 4'd9, 32'd7});
    tick(3);
    chk("halt_stays", {halted, pc, instret}, {1'b1, 4'd9, 32'd7});
    chk_quiet("halt");

    // Program B: illegal opcode at PC=1, then reset out of ERROR
    imem[0] = 32'h0020_81B3;
    imem[1] = 32'h0000_007F;
    do_reset(2);
    chk("b_rst", {halted, pc, instret}, 0);
    tick(4);
    chk("b_pc1", {pc, instret}, {4'd1, 32'd1});
    tick(1);
    chk("b_c2_no_illegal", illegal, 0);
    tick(1);
    chk("b_c3_illegal", {illegal, halted, pc, instret}, {1'b1, 1'b0, 4'd1, 32'd1});
    tick(3);
    chk("b_err_stays", {illegal, pc, instret}, {1'b1, 4'd1, 32'd1});
    chk_quiet("b_err");
    reset = 1'b1;
    tick(1);
    chk("b_err_reset", {illegal, pc, instret}, 0);
    reset = 1'b0;

    // Program C: three adds then ebreak at PC=3
    imem[0] = 32'h0020_81B3;
    imem[1] = 32'h0020_81B3;
    imem[2] = 32'h0020_81B3;
    imem[3] = 32'h0010_0073;
    do_reset(1);
    tick(12);
    chk("c_pc3", {pc, instret, halted}, {4'd3, 32'd3, 1'b0});
    tick(2);
    chk("c_halt", {halted, pc, instret}, {1'b1, 4'd3, 32'd4});

    // Program D: reset during MEM of ld must suppress its write-back
    imem[0] = 32'h0080_3283;
    do_reset(1);
    tick(3);
    chk("d_in_mem", {reg_write, dm_we, mem_to_reg}, 3'b001);
    reset = 1'b1;
    tick(1);
    chk("d_reset_mid", {reg_write, pc, instret, alu_op, mem_to_reg}, 0);
    reset = 1'b0;
    tick(1);
    chk("d_refetch_decode", {reg_write, pc, instret}, 0);
    tick(2);
    chk("d_restart_mem", {reg_write, mem_to_reg}, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle control unit and PC holder that sits directly upstream of the 64-bit datapath.
- Holds the program counter and decodes the current instruction word (from the asynchronous instruction memory).
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the datapath control inputs and the data-memory write enable, then commits the datapath's next-PC value.
- Supports the RV64 subset R-type add/sub/and/or, ld, sd and beq; ebreak halts the core and any other opcode raises a sticky error.

Parameters:
IM_L, 16, instruction memory depth in words; PC width is clog2(IM_L).
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
im_data  input  32  instruction word at PC (combinational from instruction memory)
ALUzero  input  1  datapath ALU zero flag
PCnext  input  clog2(IM_L)  datapath next-PC (PC+1 or PC+imm)
PC  output  clog2(IM_L)  program counter register (word index)
RegWrite  output  1  register file write enable
ALUsrc  output  1  1 = ALU B from rs2, 0 = ALU B from immediate
PCsrc  output  1  1 = datapath selects PC+imm
MemtoReg  output  1  1 = write-back from data memory
instType  output  2  00 R, 01 I, 10 S, 11 B
ALUop  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB
dm_we  output  1  data memory write strobe
halted  output  1  ebreak retired; core stopped
illegal  output  1  unsupported opcode/funct seen; core stopped
instret  output  CNT_W  retired-instruction counter

Behaviour:
- Reset (sync, active-high; dominates every other event including mid-instruction): PC=0, state=FETCH, instret=0, halted=0, illegal=0, IR=0. All strobes (RegWrite, dm_we, PCsrc) are 0 in every state where they are not explicitly asserted.
- FETCH (1 cycle): IR <= im_data.
- DECODE (1 cycle): the decoded control fields are registered from IR; they stay stable until the next FETCH.
- Decode of opcode IR[6:0]:
  - 0110011 R: funct3/funct7 {000/0000000 ADD, 000/0100000 SUB, 111/0000000 AND, 110/0000000 OR}; ALUsrc=1, instType=00, MemtoReg=0.
  - 0000011 ld (funct3 011): ALUop=ADD, ALUsrc=0, instType=01, MemtoReg=1.
  - 0100011 sd (funct3 011): ALUop=ADD, ALUsrc=0, instType=10.
  - 1100011 beq (funct3 000): ALUop=SUB, ALUsrc=1, instType=11.
  - 32'h00100073 ebreak: go to HALT.
  - Anything else: go to ERROR.
- State sequences (PC <= PCnext and instret+1 on the final cycle):
  - R-type: FETCH, DECODE, EXEC, WB. RegWrite=1 in WB only. 4 cycles.
  - ld: FETCH, DECODE, EXEC, MEM, WB. The data memory is read in MEM; MemtoReg=1 and RegWrite=1 in WB. 5 cycles.
  - sd: FETCH, DECODE, EXEC, MEM. dm_we=1 for exactly the MEM cycle. 4 cycles.
  - beq: FETCH, DECODE, EXEC. PCsrc = ALUzero, combinational, valid in EXEC only; PC <= PCnext at the end of EXEC. 3 cycles.
- HALT: entered on the cycle after DECODE of ebreak. halted=1 and instret is incremented once; PC is not advanced. All strobes are 0. Exit only by reset.
- ERROR: entered on the cycle after DECODE of an illegal instruction. illegal=1 and instret is not incremented. All strobes are 0. Exit only by reset.
- PC is clog2(IM_L) bits and wraps modulo IM_L. instret wraps modulo 2^CNT_W.
- Exactly one RegWrite or dm_we pulse per retired ld/R/sd. Never both in the same instruction.

Test Plan:
- Reset held for 2 cycles, then released with imem[0]=0x002081B3 (add x3,x1,x2; x1=5, x2=7) -> RegWrite high only in cycle 4, x3=12, PC=1, instret=1.
- imem[0]=0x402081B3 (sub, x1=5, x2=7) -> ALUop=0110, ALUsrc=1, x3=0xFFFF_FFFF_FFFF_FFFE.
- sd 0x00503823 (x5=0xAB) then ld 0x00803283 (ld x5,8(x0) with mem[8] preloaded 0x55) -> dm_we is a single pulse in cycle 4 with mem[16]=0xAB; ld writes x5=0x55 in cycle 5 of its sequence; instret=2 after 9 cycles.
- beq 0x00000263 at PC=2, once with x0==x0 and once as beq x1,x2 with x1!=x2 -> taken case gives PCsrc=1 in EXEC and PC=6; not-taken case gives PCsrc=0 and PC=3; each takes 3 cycles.
- Opcode 0x0000007F at PC=1 -> illegal=1 from cycle 3, PC stays 1, no strobes thereafter. Reset asserted during ERROR -> illegal=0, PC=0.
- ebreak at PC=3 after 3 add instructions -> halted=1, instret=4. Reset asserted mid-ld (during MEM) -> RegWrite never asserts, PC=0, state=FETCH.
